// File: rtl/jt51_wrbuf.sv
// jt51_wrbuf: CPU-side write buffer in front of the JT51 register block.
// CPU writes {a0, din} are queued in a small FIFO and replayed one at a time
// with the write/a0/d_in handshake, waiting for busy to rise and fall between
// entries.
// Optional feature: define JT51_WRBUF_OVF_EN to build the sticky overflow
// flag. Without it, ovf is tied low, ovf_clr is ignored and drops are silent.
module jt51_wrbuf #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_n,
  input  logic          wr_n,
  input  logic          a0,
  input  logic [7:0]    din,
  input  logic          busy_in,
  output logic          write,
  output logic          a0_out,
  output logic [7:0]    d_out,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT
  } state_t;

  // FIFO storage, one entry per CPU write: {a0, data}
  logic [8:0]    mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          wr_n_l_reg;

  state_t        state_reg;
  state_t        state_next;
  logic          write_reg;
  logic          write_next;
  logic          a0_out_reg;
  logic [7:0]    d_out_reg;

  logic          push_req;
  logic          push_ok;
  logic          drop;
  logic          pop;

  // Status comes straight from the registered entry count
  assign full  = (level_reg == LEVEL_FULL);
  assign empty = (level_reg == '0);
  assign level = level_reg;

  assign write  = write_reg;
  assign a0_out = a0_out_reg;
  assign d_out  = d_out_reg;

  // One push per low pulse of wr_n: only the falling edge (as seen against
  // the previous-cycle copy) counts, however long the strobe is held.
  assign push_req = !cs_n && !wr_n && wr_n_l_reg;
  // A pop on the same edge frees a slot, so a push into a full FIFO is still
  // accepted when the drain FSM is popping at the same time.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Previous-cycle copy of the CPU write strobe
  always_ff @(posedge clk) begin
    if (rst) wr_n_l_reg <= 1'b1;
    else     wr_n_l_reg <= wr_n;
  end

  // FIFO storage write port (no reset so it can map to RAM)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= {a0, din};
  end

  // Write/read pointers, wrapping naturally modulo the depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Entry count: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Drain FSM next-state and issue decision. busy_in is only looked at in
  // IDLE and WAIT; SETTLE hides the cycle where the register block's busy
  // is still on its way up after the strobe.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    write_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty && !busy_in) begin
          pop        = 1'b1;
          write_next = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!busy_in) begin
          if (!empty) begin
            pop        = 1'b1;
            write_next = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Drain FSM state register and one-cycle write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      write_reg <= write_next;
    end
  end

  // Registered read of the head entry; a0_out/d_out hold between issues
  always_ff @(posedge clk) begin
    if (rst) begin
      a0_out_reg <= 1'b0;
      d_out_reg  <= 8'h00;
    end else if (pop) begin
      {a0_out_reg, d_out_reg} <= mem[rd_ptr_reg];
    end
  end

`ifdef JT51_WRBUF_OVF_EN
  logic ovf_reg;

  // Sticky overflow: a drop on the same edge as a clear keeps it set
  always_ff @(posedge clk) begin
    if (rst)          ovf_reg <= 1'b0;
    else if (drop)    ovf_reg <= 1'b1;
    else if (ovf_clr) ovf_reg <= 1'b0;
  end

  assign ovf = ovf_reg;
`else
  // Overflow reporting not built: drops happen silently
  logic unused_ovf;
  assign unused_ovf = ovf_clr ^ drop;
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jt51_wrbuf.sv
// Testbench for jt51_wrbuf: scoreboard of expected register-block writes,
// one task per scenario, outputs sampled on the falling clock edge.
module tb_jt51_wrbuf;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs_n;
  logic          wr_n;
  logic          a0;
  logic [7:0]    din;
  logic          busy_in;
  logic          write;
  logic          a0_out;
  logic [7:0]    d_out;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          ovf;
  logic          ovf_clr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwr = 0;
  int last_wr_cyc = 0;
  logic prev_write = 1'b0;
  logic [8:0] sb[$];
  int wr_cyc[$];

  // Automatic busy responder: busy rises two cycles after each write and
  // stays high for five cycles.
  logic auto_busy = 1'b0;
  int arm = 0;
  int hold = 0;

  jt51_wrbuf #(.AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs_n    (cs_n),
    .wr_n    (wr_n),
    .a0      (a0),
    .din     (din),
    .busy_in (busy_in),
    .write   (write),
    .a0_out  (a0_out),
    .d_out   (d_out),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe pops the scoreboard and is compared
  always @(negedge clk) begin
    if (!rst && write) begin
      checks++;
      if (prev_write) begin
        errors++;
        $display("FAIL write_width: write high on consecutive cycles at cyc %0d, required single cycle", cyc);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: unexpected write a0=%0d d=%02h, required no write", a0_out, d_out);
      end else begin
        logic [8:0] exp_e;
        exp_e = sb.pop_front();
        if ({a0_out, d_out} !== exp_e) begin
          errors++;
          $display("FAIL sb_data: got a0=%0d d=%02h, required a0=%0d d=%02h",
                   a0_out, d_out, exp_e[8], exp_e[7:0]);
        end
        $display("write #%0d at cyc %0d: a0=%0d d=%02h", nwr + 1, cyc, a0_out, d_out);
      end
      nwr++;
      last_wr_cyc = cyc;
      wr_cyc.push_back(cyc);
    end
    prev_write = write;
  end

  // Busy responder for the throughput scenario
  always @(negedge clk) begin
    if (auto_busy) begin
      if (write) arm = 2;
      else if (arm == 2) arm = 1;
      else if (arm == 1) begin
        arm = 0;
        busy_in = 1'b1;
        hold = 5;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) busy_in = 1'b0;
      end
    end
  end

  task automatic do_push(input logic a0v, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0;
    wr_n = 1'b0;
    a0   = a0v;
    din  = d;
    @(negedge clk);
    wr_n = 1'b1;
    cs_n = 1'b1;
    $display("push a0=%0d d=%02h at cyc %0d level=%0d", a0v, d, cyc, level);
  endtask

  task automatic test_reset;
    rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    busy_in = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({write, a0_out, d_out, empty, full, level, ovf} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got write=%0d a0=%0d d=%02h empty=%0d full=%0d level=%0d ovf=%0d, required 0 0 00 1 0 0 0",
               write, a0_out, d_out, empty, full, level, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int push_cyc;
    sb.push_back({1'b0, 8'h14});
    do_push(1'b0, 8'h14);
    push_cyc = cyc;
    checks++;
    if (level !== 4'd1) begin
      errors++;
      $display("FAIL single_level_push: got %0d, required 1", level);
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || cyc != push_cyc + 1) begin
      errors++;
      $display("FAIL single_latency: write=%0d at cyc %0d, required 1 at cyc %0d", write, cyc, push_cyc + 1);
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0) begin
      errors++;
      $display("FAIL single_width: write=%0d one cycle later, required 0", write);
    end
    checks++;
    if (level !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_level_drain: got level=%0d empty=%0d, required 0 1", level, empty);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_spacing;
    wr_cyc.delete();
    auto_busy = 1'b1;
    sb.push_back({1'b0, 8'h20});
    do_push(1'b0, 8'h20);
    sb.push_back({1'b1, 8'hC7});
    do_push(1'b1, 8'hC7);
    sb.push_back({1'b0, 8'h08});
    do_push(1'b0, 8'h08);
    for (int i = 0; i < 100 && wr_cyc.size() < 3; i++) @(negedge clk);
    checks++;
    if (wr_cyc.size() != 3) begin
      errors++;
      $display("FAIL spacing_count: got %0d writes, required 3", wr_cyc.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (wr_cyc[k] - wr_cyc[k-1] != 8) begin
          errors++;
          $display("FAIL spacing_gap%0d: got %0d cycles, required 8", k, wr_cyc[k] - wr_cyc[k-1]);
        end
      end
    end
    repeat (15) @(negedge clk);
    auto_busy = 1'b0;
    busy_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_drop;
    int base;
    logic exp_ovf;
`ifdef JT51_WRBUF_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    busy_in = 1'b1;
    base = nwr;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] d;
      d = 8'h30 + 8'(i);
      if (i < 8) sb.push_back({1'(i & 1), d});
      do_push(1'(i & 1), d);
      if (i == 7) begin
        checks++;
        if (full !== 1'b1 || level !== 4'd8) begin
          errors++;
          $display("FAIL full_after_8: got full=%0d level=%0d, required 1 8", full, level);
        end
      end
    end
    checks++;
    if (level !== 4'd8 || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL drop_9th: got level=%0d ovf=%0d, required 8 %0d", level, ovf, exp_ovf);
    end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %0d, required 0", ovf);
    end
    busy_in = 1'b0;
    for (int i = 0; i < 200 && nwr < base + 8; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (nwr - base != 8 || empty !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_8: got %0d writes empty=%0d pending=%0d, required 8 1 0", nwr - base, empty, sb.size());
    end
  endtask

  task automatic test_full_push_pop;
    int base;
    busy_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sb.push_back({1'b0, 8'h60 + 8'(i)});
      do_push(1'b0, 8'h60 + 8'(i));
    end
    base = nwr;
    @(negedge clk);
    busy_in = 1'b0;
    cs_n = 1'b0;
    wr_n = 1'b0;
    a0   = 1'b1;
    din  = 8'hA5;
    sb.push_back({1'b1, 8'hA5});
    @(negedge clk);
    busy_in = 1'b1;
    wr_n = 1'b1;
    cs_n = 1'b1;
    checks++;
    if (level !== 4'd8 || full !== 1'b1 || ovf !== 1'b0 || write !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_full: got level=%0d full=%0d ovf=%0d write=%0d, required 8 1 0 1",
               level, full, ovf, write);
    end
    repeat (3) @(negedge clk);
    busy_in = 1'b0;
    for (int i = 0; i < 200 && nwr < base + 9; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (nwr - base != 9 || level !== 4'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL push_pop_drain: got %0d writes level=%0d pending=%0d, required 9 0 0", nwr - base, level, sb.size());
    end
  endtask

  task automatic test_strobe;
    busy_in = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    wr_n = 1'b0;
    a0   = 1'b0;
    din  = 8'h5A;
    sb.push_back({1'b0, 8'h5A});
    repeat (10) @(negedge clk);
    wr_n = 1'b1;
    cs_n = 1'b1;
    checks++;
    if (level !== 4'd1) begin
      errors++;
      $display("FAIL long_strobe: got level=%0d, required 1", level);
    end
    @(negedge clk);
    cs_n = 1'b1;
    wr_n = 1'b0;
    din  = 8'hFF;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (level !== 4'd1) begin
      errors++;
      $display("FAIL cs_high: got level=%0d, required 1", level);
    end
    busy_in = 1'b0;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (level !== 4'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL strobe_drain: got level=%0d pending=%0d, required 0 0", level, sb.size());
    end
  endtask

  task automatic test_reset_mid;
    int base;
    busy_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sb.push_back({1'b1, 8'h90 + 8'(i)});
      do_push(1'b1, 8'h90 + 8'(i));
    end
    busy_in = 1'b0;
    @(negedge clk);
    busy_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (level !== 4'd4) begin
      errors++;
      $display("FAIL mid_level: got %0d, required 4", level);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got write=%0d level=%0d empty=%0d full=%0d, required 0 0 1 0",
               write, level, empty, full);
    end
    sb.delete();
    rst = 1'b0;
    busy_in = 1'b0;
    base = nwr;
    repeat (20) @(negedge clk);
    checks++;
    if (nwr != base) begin
      errors++;
      $display("FAIL mid_no_write: got %0d writes after reset, required 0", nwr - base);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_spacing();
    test_full_drop();
    test_full_push_pop();
    test_strobe();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
